// File: rtl/joy_serial_tx_if.sv
// rtl/joy_serial_tx_if.sv - serial joystick chain pin bundle
// Purpose: groups the three chain pins between the host reader and the responder.
// Signals:
//   joy_clk  - host shift clock, rising edge active
//   joy_load - host load strobe, active low
//   joy_data - serial slot data back to the host
// Modports: master = host side, slave = responder side.
interface joy_serial_tx_if;
  logic joy_clk;
  logic joy_load;
  logic joy_data;

  modport master (output joy_clk, output joy_load, input joy_data);
  modport slave  (input joy_clk, input joy_load, output joy_data);
endinterface

// File: rtl/joy_serial_tx.sv
// rtl/joy_serial_tx.sv - two-player serial joystick chain responder
// Purpose: stands in for the external joystick shift registers; on a host load
// captures both active-low joystick states into a 26-slot frame and presents one
// slot per host clock rise on joy_data.
// Ports:
//   clk_48M    - system clock (>= 8x joy_clk)
//   reset      - synchronous active-high reset
//   joy        - chain pins (slave modport): joy_clk, joy_load in, joy_data out
//   joy1_n     - player-1 state, active low
//   joy2_n     - player-2 state, active low
//   bit_index  - slot on joy_data, 0..25, 26 when idle
//   frame_done - one-cycle pulse when slot 25 is shifted out
//   resync     - one-cycle pulse when a load interrupts a frame in flight
module joy_serial_tx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_48M,
  input  logic             reset,
  joy_serial_tx_if.slave   joy,
  input  logic [11:0]      joy1_n,
  input  logic [11:0]      joy2_n,
  output logic [4:0]       bit_index,
  output logic             frame_done,
  output logic             resync
);

  localparam logic [4:0] IDX_LAST = 5'd25;
  localparam logic [4:0] IDX_IDLE = 5'd26;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] load_sync_q;
  logic                   clk_dly_q;
  logic [25:0]            frame_q;
  logic                   joy_data_q;
  logic [4:0]             bit_index_q;
  logic                   frame_done_q;
  logic                   resync_q;

  logic [25:0]            frame_d;
  logic                   evt;
  logic                   load_evt;

  // Slot n of the frame lives in bit n; slot 0 is presented first.
  assign frame_d = {joy1_n[7], joy1_n[9], joy1_n[11], joy1_n[10],
                    joy2_n[7], joy2_n[9], joy2_n[11], joy2_n[10],
                    joy2_n[0], joy2_n[1], joy2_n[2], joy2_n[3],
                    joy2_n[4], joy2_n[5], joy2_n[6], joy2_n[8],
                    joy1_n[0], joy1_n[1], joy1_n[2], joy1_n[3],
                    joy1_n[4], joy1_n[5], joy1_n[6], joy1_n[8],
                    2'b11};

  assign evt      = clk_sync_q[SYNC_STAGES-1] & ~clk_dly_q;
  assign load_evt = evt & ~load_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_48M) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      clk_sync_q   <= '1;
      load_sync_q  <= '1;
      clk_dly_q    <= 1'b1;
      frame_q      <= '1;
      joy_data_q   <= 1'b1;
      bit_index_q  <= IDX_IDLE;
      frame_done_q <= 1'b0;
      resync_q     <= 1'b0;
    end else begin
      clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], joy.joy_clk};
      load_sync_q  <= {load_sync_q[SYNC_STAGES-2:0], joy.joy_load};
      clk_dly_q    <= clk_sync_q[SYNC_STAGES-1];
      frame_done_q <= 1'b0;
      resync_q     <= 1'b0;

      if (load_evt) begin
        // frame_q holds the slots still to come, already shifted by one.
        frame_q     <= {1'b1, frame_d[25:1]};
        joy_data_q  <= frame_d[0];
        resync_q    <= (state_q == ST_SHIFT) && (bit_index_q != 5'd0);
        bit_index_q <= 5'd0;
        state_q     <= ST_SHIFT;
      end else if (evt && state_q == ST_SHIFT) begin
        if (bit_index_q == IDX_LAST) begin
          frame_q      <= '1;
          joy_data_q   <= 1'b1;
          bit_index_q  <= IDX_IDLE;
          frame_done_q <= 1'b1;
          state_q      <= ST_IDLE;
        end else begin
          frame_q     <= {1'b1, frame_q[25:1]};
          joy_data_q  <= frame_q[0];
          bit_index_q <= bit_index_q + 5'd1;
        end
      end
    end
  end

  assign joy.joy_data = joy_data_q;
  assign bit_index    = bit_index_q;
  assign frame_done   = frame_done_q;
  assign resync       = resync_q;

endmodule

// File: tb/tb_joy_serial_tx.sv
// tb/tb_joy_serial_tx.sv - scoreboard bench for joy_serial_tx
module tb_joy_serial_tx;

  logic        clk_48M = 1'b0;
  logic        reset;
  logic [11:0] joy1_n;
  logic [11:0] joy2_n;
  logic [4:0]  bit_index;
  logic        frame_done;
  logic        resync;

  always #5 clk_48M = ~clk_48M;

  joy_serial_tx_if joy ();

  joy_serial_tx #(.SYNC_STAGES(2)) dut (
    .clk_48M    (clk_48M),
    .reset      (reset),
    .joy        (joy),
    .joy1_n     (joy1_n),
    .joy2_n     (joy2_n),
    .bit_index  (bit_index),
    .frame_done (frame_done),
    .resync     (resync)
  );

  typedef struct packed {
    logic       data;
    logic [4:0] idx;
    logic       done;
    logic       rs;
  } exp_t;

  exp_t q[$];
  exp_t prev;
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   rs_cnt = 0;
  bit   mon_go = 1'b0;

  // reference model state
  logic [11:0] m_j1, m_j2;
  int          m_idx;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic slot_val(input logic [11:0] a, input logic [11:0] b, input int s);
    case (s)
      2:  return a[8];  3:  return a[6];  4:  return a[5];  5:  return a[4];
      6:  return a[3];  7:  return a[2];  8:  return a[1];  9:  return a[0];
      10: return b[8];  11: return b[6];  12: return b[5];  13: return b[4];
      14: return b[3];  15: return b[2];  16: return b[1];  17: return b[0];
      18: return b[10]; 19: return b[11]; 20: return b[9];  21: return b[7];
      22: return a[10]; 23: return a[11]; 24: return a[9];  25: return a[7];
      default: return 1'b1;
    endcase
  endfunction

  // One full joy_clk period (128 cycles): low half, rise, high half.
  task automatic edge_ev(input bit ld);
    exp_t e;
    @(negedge clk_48M);
    joy.joy_load = ld ? 1'b0 : 1'b1;
    repeat (63) @(negedge clk_48M);
    e.done = 1'b0;
    e.rs   = 1'b0;
    if (ld) begin
      e.rs  = (m_idx >= 1 && m_idx <= 25);
      m_j1  = joy1_n;
      m_j2  = joy2_n;
      m_idx = 0;
    end else if (m_idx < 25) begin
      m_idx++;
    end else if (m_idx == 25) begin
      m_idx  = 26;
      e.done = 1'b1;
    end
    e.idx  = 5'(m_idx);
    e.data = (m_idx == 26) ? 1'b1 : slot_val(m_j1, m_j2, m_idx);
    q.push_back(e);
    joy.joy_clk = 1'b1;
    repeat (64) @(negedge clk_48M);
    joy.joy_clk  = 1'b0;
    joy.joy_load = 1'b1;
  endtask

  task automatic do_reset();
    exp_t e;
    @(negedge clk_48M);
    e = '{data: 1'b1, idx: 5'd26, done: 1'b0, rs: 1'b0};
    m_idx = 26;
    q.push_back(e);
    reset = 1'b1;
    repeat (3) @(negedge clk_48M);
    reset = 1'b0;
  endtask

  // Monitor: after each host rise, outputs must hold until E0+2 and then match.
  initial begin
    exp_t e;
    wait (mon_go);
    forever begin
      @(posedge joy.joy_clk or posedge reset);
      if (reset) begin
        @(negedge reset);
        @(negedge clk_48M);
        if (q.size() == 0) chk("queue_empty_rst", 32'd0, 32'd1);
        else begin
          e = q.pop_front();
          chk("rst_data", joy.joy_data, e.data);
          chk("rst_idx", bit_index, e.idx);
          chk("rst_pulses", {frame_done, resync}, 2'b00);
          prev = e;
        end
      end else begin
        @(posedge clk_48M);
        @(posedge clk_48M);
        @(negedge clk_48M);
        chk("early_data", joy.joy_data, prev.data);
        chk("early_idx", bit_index, prev.idx);
        chk("early_pulses", {frame_done, resync}, 2'b00);
        @(posedge clk_48M);
        @(negedge clk_48M);
        if (q.size() == 0) chk("queue_empty", 32'd0, 32'd1);
        else begin
          e = q.pop_front();
          chk("data", joy.joy_data, e.data);
          chk("idx", bit_index, e.idx);
          chk("frame_done", frame_done, e.done);
          chk("resync", resync, e.rs);
          if (frame_done === 1'b1) done_cnt++;
          if (resync === 1'b1) rs_cnt++;
          prev = e;
        end
        @(posedge clk_48M);
        @(negedge clk_48M);
        chk("pulse_width", {frame_done, resync}, 2'b00);
      end
    end
  end

  initial begin
    int d0, r0;
    joy.joy_clk  = 1'b0;
    joy.joy_load = 1'b1;
    reset  = 1'b1;
    joy1_n = '1;
    joy2_n = '1;
    m_j1   = '1;
    m_j2   = '1;
    m_idx  = 26;
    repeat (5) @(negedge clk_48M);
    chk("reset_data", joy.joy_data, 1'b1);
    chk("reset_idx", bit_index, 5'd26);
    chk("reset_pulses", {frame_done, resync}, 2'b00);
    reset = 1'b0;
    @(negedge clk_48M);
    prev   = '{data: 1'b1, idx: 5'd26, done: 1'b0, rs: 1'b0};
    mon_go = 1'b1;

    // idle after reset
    d0 = done_cnt;
    repeat (30) edge_ev(1'b0);
    chk("idle_idx", bit_index, 5'd26);
    chk("idle_done_count", done_cnt - d0, 0);

    // full frame
    joy1_n = 12'hFFE;
    joy2_n = 12'hEFF;
    d0 = done_cnt;
    edge_ev(1'b1);
    repeat (26) edge_ev(1'b0);
    chk("ff_end_idx", bit_index, 5'd26);
    chk("ff_done_count", done_cnt - d0, 1);

    // mid-frame reload
    joy1_n = '1;
    joy2_n = '1;
    edge_ev(1'b1);
    repeat (12) edge_ev(1'b0);
    joy1_n = 12'h000;
    r0 = rs_cnt;
    edge_ev(1'b1);
    chk("reload_idx", bit_index, 5'd0);
    chk("reload_rs_count", rs_cnt - r0, 1);
    repeat (26) edge_ev(1'b0);

    // input change mid-frame
    joy1_n = '1;
    joy2_n = '1;
    edge_ev(1'b1);
    repeat (5) edge_ev(1'b0);
    joy2_n = 12'h000;
    repeat (21) edge_ev(1'b0);
    chk("chg_end_idx", bit_index, 5'd26);

    // reset mid-frame
    joy2_n = '1;
    edge_ev(1'b1);
    repeat (14) edge_ev(1'b0);
    d0 = done_cnt;
    do_reset();
    edge_ev(1'b0);
    edge_ev(1'b0);
    chk("rstmid_idx", bit_index, 5'd26);
    chk("rstmid_data", joy.joy_data, 1'b1);
    chk("rstmid_done_count", done_cnt - d0, 0);

    repeat (10) @(negedge clk_48M);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
